// File: rtl/pc_pkg.sv
// Shared defaults and the action encoding for the fetch-address unit.
// The priority order of the redirect actions is fixed in one place: decode_action().
package pc_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_RAS_DEPTH  = 8;
  localparam int DEF_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    ACT_BRANCH = 3'd0,
    ACT_CALL   = 3'd1,
    ACT_RET    = 3'd2,
    ACT_HOLD   = 3'd3,
    ACT_INC    = 3'd4
  } action_e;

  // Exactly one action is chosen each cycle. When call and ret arrive together,
  // the call wins and the ret is dropped without popping the stack.
  function automatic action_e decode_action(input logic branch, input logic call,
                                            input logic ret, input logic stall);
    if (branch)     return ACT_BRANCH;
    else if (call)  return ACT_CALL;
    else if (ret)   return ACT_RET;
    else if (stall) return ACT_HOLD;
    else            return ACT_INC;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. When the stack is full, a push overwrites the oldest entry.
// On reset only the pointer and the count are cleared, so the entry storage keeps stale data.
module ras_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;

  // wr_ptr names the next free slot. The slot just below it holds the newest entry.
  assign top_ptr  = wr_ptr - 1'b1;
  assign top_data = mem[top_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-address register with branch/call/return redirect and a return-address stack.
// Any control input takes effect on instr_address one clock after it is presented.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RAS_DEPTH  = DEF_RAS_DEPTH,
  parameter int RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         call,
  input  logic                         ret,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         clr_err,
  output logic [ADDR_W-1:0]            instr_address,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  action_e           action;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] top_data;
  logic              push;
  logic              pop;
  logic              ovf_evt;
  logic              unf_evt;

  assign action   = decode_action(branch, call, ret, stall);
  assign pc_plus1 = instr_address + 1'b1;

  always_comb begin
    next_pc = instr_address;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (action)
      ACT_BRANCH: next_pc = target;
      ACT_CALL: begin
        next_pc = target;
        push    = 1'b1;
        ovf_evt = ras_full;
      end
      ACT_RET: begin
        if (!ras_empty) begin
          next_pc = top_data;
          pop     = 1'b1;
        end else begin
          next_pc = pc_plus1;
          unf_evt = 1'b1;
        end
      end
      ACT_HOLD: next_pc = instr_address;
      ACT_INC:  next_pc = pc_plus1;
      default:  next_pc = instr_address;
    endcase
  end

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH),
    .CNT_W  (CNT_W)
  ) u_ras_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top_data  (top_data),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instr_address <= ADDR_W'(RESET_ADDR);
    else       instr_address <= next_pc;
  end

  // If an error event and clr_err occur in the same cycle, the event wins and the flag stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (ovf_evt)      ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
      if (unf_evt)      unf_err <= 1'b1;
      else if (clr_err) unf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: a queue-based reference model predicts each cycle's outputs.
// A monitor process compares those predictions after every clock edge.
module tb_pc_ras_unit;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b1;
  logic              branch = 1'b0;
  logic              call = 1'b0;
  logic              ret = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] instr_address;
  logic [3:0]        ras_count;
  logic              ras_full, ras_empty, ovf_err, unf_err;

  pc_ras_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .call(call), .ret(ret),
    .target(target), .clr_err(clr_err), .instr_address(instr_address),
    .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    int                cnt;
    bit                ovf;
    bit                unf;
    string             tag;
  } exp_t;

  exp_t exp_q[$];

  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_stk[$];
  bit                m_ovf, m_unf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of stimulus, then push the expected post-edge state.
  task automatic step(input bit b, input bit c, input bit r, input bit s,
                      input logic [ADDR_W-1:0] t, input bit clr, input string tag);
    bit ovf_ev, unf_ev;
    @(negedge clk);
    branch = b; call = c; ret = r; stall = s; target = t; clr_err = clr;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (b) begin
      m_pc = t;
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        ovf_ev = 1'b1;
      end
      m_stk.push_back(m_pc + 1'b1);
      m_pc = t;
    end else if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc = m_pc + 1'b1;
        unf_ev = 1'b1;
      end
    end else if (!s) begin
      m_pc = m_pc + 1'b1;
    end
    m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = unf_ev ? 1'b1 : (clr ? 1'b0 : m_unf);
    exp_q.push_back('{pc: m_pc, cnt: m_stk.size(), ovf: m_ovf, unf: m_unf, tag: tag});
  endtask

  task automatic idle_inputs();
    branch = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b1; clr_err = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    32'(instr_address), 32'd0);
    chk({tag, "_count"}, 32'(ras_count),     32'd0);
    chk({tag, "_empty"}, 32'(ras_empty),     32'd1);
    chk({tag, "_full"},  32'(ras_full),      32'd0);
    chk({tag, "_ovf"},   32'(ovf_err),       32'd0);
    chk({tag, "_unf"},   32'(unf_err),       32'd0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_pc"},    32'(instr_address), 32'(e.pc));
      chk({e.tag, "_count"}, 32'(ras_count),     32'(e.cnt));
      chk({e.tag, "_full"},  32'(ras_full),      32'(e.cnt == DEPTH));
      chk({e.tag, "_empty"}, 32'(ras_empty),     32'(e.cnt == 0));
      chk({e.tag, "_ovf"},   32'(ovf_err),       32'(e.ovf));
      chk({e.tag, "_unf"},   32'(unf_err),       32'(e.unf));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    #2 reset = 1'b1;
    #1 chk_reset_state("reset_init");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0, 0, "inc");
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, '0, 0, "stall_hold");
    step(0, 0, 0, 0, '0, 0, "inc_to5");

    step(0, 1, 0, 0, 10'h100, 0, "call_100");
    step(0, 0, 1, 0, '0, 0, "ret_to6");

    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 10'(16 * i + 32), 0, "nested_call");
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, '0, 0, "nested_ret");
    step(0, 0, 1, 0, '0, 0, "ret_underflow");

    step(0, 0, 1, 0, '0, 1, "clr_with_unf");
    step(0, 0, 0, 0, '0, 1, "clr_alone");

    step(0, 1, 0, 0, 10'h050, 0, "pre_call");
    step(1, 1, 1, 1, 10'h3FF, 0, "all_ctrl");
    step(0, 0, 0, 0, '0, 0, "wrap_to_0");
    step(0, 1, 1, 0, 10'h200, 0, "call_and_ret");

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 10'(64 + i), 0, "call_before_rst");
    @(posedge clk);
    #3 reset = 1'b1;
    idle_inputs();
    #1 chk_reset_state("reset_mid");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, '0, 0, "resume_inc");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25,
           10'($urandom), $urandom_range(0, 99) < 6, "random");
    end

    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
